// File: rtl/wb_unit.sv
// wb_unit -- writeback stage between execute/LSU and the GPR file.
//
// Accepts one retiring instruction per valid/ready handshake, picks the ALU,
// CSR or load result, extends/aligns load data and drives a single registered
// write strobe/address/data into the register file. Loads park the unit in
// WAIT_LOAD (front end stalled) until the LSU response arrives or a bounded
// timeout expires, in which case a one-cycle error pulse is raised instead.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   ex_wb_valid/ready          execute handshake (ready decoded from state)
//   ex_wb_typ                  00 ALU, 01 load, 10 CSR read, 11 no writeback
//   ex_wb_rd_addr              destination register
//   ex_wb_alu_data/csr_rdata   candidate result values
//   ex_wb_funct3/byte_off      load size/sign and address bits [1:0]
//   lsu_wb_valid/rdata         one-cycle load response, raw 32-bit word
//   wb_gpr_write_en/addr/wdata registered register-file write port
//   wb_ifu_stall               high while a load is outstanding
//   wb_load_pending_addr       rd of outstanding load, else 0
//   wb_load_err                one-cycle pulse on load timeout
module wb_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int LSU_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_wb_valid,
    output logic                  ex_wb_ready,
    input  logic [1:0]            ex_wb_typ,
    input  logic [ADDR_WIDTH-1:0] ex_wb_rd_addr,
    input  logic [DATA_WIDTH-1:0] ex_wb_alu_data,
    input  logic [DATA_WIDTH-1:0] ex_wb_csr_rdata,
    input  logic [2:0]            ex_wb_funct3,
    input  logic [1:0]            ex_wb_byte_off,
    input  logic                  lsu_wb_valid,
    input  logic [DATA_WIDTH-1:0] lsu_wb_rdata,
    output logic                  wb_gpr_write_en,
    output logic [ADDR_WIDTH-1:0] wb_gpr_write_addr,
    output logic [DATA_WIDTH-1:0] wb_gpr_wdata,
    output logic                  wb_ifu_stall,
    output logic [ADDR_WIDTH-1:0] wb_load_pending_addr,
    output logic                  wb_load_err
);

    localparam int            CW       = $clog2(LSU_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(LSU_TIMEOUT - 1);

    localparam logic [1:0] TYP_ALU  = 2'b00;
    localparam logic [1:0] TYP_LOAD = 2'b01;
    localparam logic [1:0] TYP_CSR  = 2'b10;

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    // Cleared by reset, set on the first edge out of reset: keeps ready low
    // while reset is held without a combinational path from rst_n.
    logic                    run_q;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   ld_rd_q, ld_rd_d;
    logic [2:0]              ld_f3_q, ld_f3_d;
    logic [1:0]              ld_off_q, ld_off_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    err_q, err_d;

    logic [7:0]              ld_byte;
    logic [15:0]             ld_half;
    logic [DATA_WIDTH-1:0]   ld_ext;

    // ------------------------------------------------------------------
    // Load data extraction from the raw word using the captured size/offset
    // ------------------------------------------------------------------
    always_comb begin
        ld_byte = lsu_wb_rdata[{ld_off_q, 3'b000} +: 8];
        ld_half = ld_off_q[1] ? lsu_wb_rdata[31:16] : lsu_wb_rdata[15:0];
        case (ld_f3_q)
            3'b000:  ld_ext = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
            3'b101:  ld_ext = {{(DATA_WIDTH-16){1'b0}}, ld_half};
            default: ld_ext = lsu_wb_rdata;  // LW and unused encodings
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ld_rd_d  = ld_rd_q;
        ld_f3_d  = ld_f3_q;
        ld_off_d = ld_off_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (ex_wb_valid && ex_wb_ready) begin
                    case (ex_wb_typ)
                        TYP_ALU, TYP_CSR: begin
                            // x0 writes are swallowed; addr/data keep last values
                            if (ex_wb_rd_addr != '0) begin
                                we_d    = 1'b1;
                                waddr_d = ex_wb_rd_addr;
                                wdata_d = (ex_wb_typ == TYP_CSR) ? ex_wb_csr_rdata
                                                                 : ex_wb_alu_data;
                            end
                        end
                        TYP_LOAD: begin
                            ld_rd_d  = ex_wb_rd_addr;
                            ld_f3_d  = ex_wb_funct3;
                            ld_off_d = ex_wb_byte_off;
                            cnt_d    = '0;
                            state_d  = WAIT_LOAD;
                        end
                        default: ;  // no writeback
                    endcase
                end
            end
            WAIT_LOAD: begin
                // A response on the expiry cycle takes priority over the timeout.
                if (lsu_wb_valid) begin
                    state_d = IDLE;
                    if (ld_rd_q != '0) begin
                        we_d    = 1'b1;
                        waddr_d = ld_rd_q;
                        wdata_d = ld_ext;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            ld_rd_q  <= '0;
            ld_f3_q  <= '0;
            ld_off_q <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            ld_rd_q  <= ld_rd_d;
            ld_f3_q  <= ld_f3_d;
            ld_off_q <= ld_off_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
        end
    end

    assign ex_wb_ready          = (state_q == IDLE) && run_q;
    assign wb_ifu_stall         = (state_q == WAIT_LOAD);
    assign wb_load_pending_addr = (state_q == WAIT_LOAD) ? ld_rd_q : '0;
    assign wb_gpr_write_en      = we_q;
    assign wb_gpr_write_addr    = waddr_q;
    assign wb_gpr_wdata         = wdata_q;
    assign wb_load_err          = err_q;

endmodule

// File: tb/tb_wb_unit.sv
// Bench for wb_unit: directed scenarios followed by random traffic. The
// driver pushes expected register-file writes / error pulses (with the cycle
// they must appear in) into a queue; a negedge monitor pops and compares.
module tb_wb_unit;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_wb_valid;
    logic        ex_wb_ready;
    logic [1:0]  ex_wb_typ;
    logic [4:0]  ex_wb_rd_addr;
    logic [31:0] ex_wb_alu_data;
    logic [31:0] ex_wb_csr_rdata;
    logic [2:0]  ex_wb_funct3;
    logic [1:0]  ex_wb_byte_off;
    logic        lsu_wb_valid;
    logic [31:0] lsu_wb_rdata;
    logic        wb_gpr_write_en;
    logic [4:0]  wb_gpr_write_addr;
    logic [31:0] wb_gpr_wdata;
    logic        wb_ifu_stall;
    logic [4:0]  wb_load_pending_addr;
    logic        wb_load_err;

    wb_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .LSU_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_wb_valid(ex_wb_valid), .ex_wb_ready(ex_wb_ready),
        .ex_wb_typ(ex_wb_typ), .ex_wb_rd_addr(ex_wb_rd_addr),
        .ex_wb_alu_data(ex_wb_alu_data), .ex_wb_csr_rdata(ex_wb_csr_rdata),
        .ex_wb_funct3(ex_wb_funct3), .ex_wb_byte_off(ex_wb_byte_off),
        .lsu_wb_valid(lsu_wb_valid), .lsu_wb_rdata(lsu_wb_rdata),
        .wb_gpr_write_en(wb_gpr_write_en), .wb_gpr_write_addr(wb_gpr_write_addr),
        .wb_gpr_wdata(wb_gpr_wdata), .wb_ifu_stall(wb_ifu_stall),
        .wb_load_pending_addr(wb_load_pending_addr), .wb_load_err(wb_load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [4:0]  addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    logic [4:0]  last_addr = '0;
    logic [31:0] last_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference load extraction written as plain arithmetic on the word.
    function automatic logic [31:0] ref_load(input int f3, input int off, input logic [31:0] w);
        int unsigned b, h;
        b = (w >> (8 * off)) % 256;
        h = (off >= 2) ? (w / 65536) : (w % 65536);
        case (f3)
            0: return (b >= 128) ? 32'(b) - 32'd256 : 32'(b);
            1: return (h >= 32768) ? 32'(h) - 32'd65536 : 32'(h);
            4: return 32'(b);
            5: return 32'(h);
            default: return w;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Monitor: compares every strobe/pulse against the scoreboard queue,
    // and checks that addr/data hold between strobes.
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (mon_en) begin
            if (wb_gpr_write_en) begin
                if (sb.size() == 0 || sb[0].is_err) begin
                    checks++; failures++;
                    $display("FAIL unexpected_write: addr %0d data 0x%08h at cyc %0d",
                             wb_gpr_write_addr, wb_gpr_wdata, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("write_addr", 32'(wb_gpr_write_addr), 32'(e.addr));
                    chk("write_data", wb_gpr_wdata, e.data);
                    chk("write_cycle", cyc, e.cyc);
                    last_addr = e.addr;
                    last_data = e.data;
                end
            end else begin
                chk("hold_addr", 32'(wb_gpr_write_addr), 32'(last_addr));
                chk("hold_data", wb_gpr_wdata, last_data);
            end
            if (wb_load_err) begin
                if (sb.size() == 0 || !sb[0].is_err) begin
                    checks++; failures++;
                    $display("FAIL unexpected_err: pulse at cyc %0d", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("err_cycle", cyc, e.cyc);
                end
            end
        end
    end

    // Issue one instruction; returns the bench cycle count of its accept edge.
    task automatic send(input int typ, input int rd, input logic [31:0] alu,
                        input logic [31:0] csr, input int f3, input int off,
                        output int acc);
        int t;
        ex_wb_valid     = 1'b1;
        ex_wb_typ       = 2'(typ);
        ex_wb_rd_addr   = 5'(rd);
        ex_wb_alu_data  = alu;
        ex_wb_csr_rdata = csr;
        ex_wb_funct3    = 3'(f3);
        ex_wb_byte_off  = 2'(off);
        t = 0;
        while (!ex_wb_ready && t < 50) begin
            @(posedge clk); #1; t++;
        end
        if (t >= 50) begin
            checks++; failures++;
            $display("FAIL ready_timeout: ready stayed 0 for 50 cycles");
        end
        @(posedge clk); #1;
        acc = cyc;
        ex_wb_valid = 1'b0;
        if ((typ == 0 || typ == 2) && rd != 0)
            sb.push_back('{is_err: 1'b0, addr: 5'(rd),
                           data: (typ == 2) ? csr : alu, cyc: acc});
    endtask

    task automatic do_alu(input int typ, input int rd, input logic [31:0] d);
        int acc;
        send(typ, rd, d, ~d, 0, 0, acc);
    endtask

    // Load whose response is sampled k edges after the accept edge.
    // For k > TO the response arrives after the timeout and must be ignored.
    task automatic do_load(input int rd, input int f3, input int off,
                           input logic [31:0] w, input int k);
        int acc;
        send(1, rd, 32'h0, 32'h0, f3, off, acc);
        if (k <= TO) begin
            if (rd != 0)
                sb.push_back('{is_err: 1'b0, addr: 5'(rd), data: ref_load(f3, off, w),
                               cyc: acc + k});
        end else begin
            sb.push_back('{is_err: 1'b1, addr: '0, data: '0, cyc: acc + TO});
        end
        for (int j = 1; j <= k; j++) begin
            chk("stall", 32'(wb_ifu_stall), (j <= TO) ? 32'd1 : 32'd0);
            chk("pending_addr", 32'(wb_load_pending_addr), (j <= TO) ? 32'(rd) : 32'd0);
            chk("ready_in_load", 32'(ex_wb_ready), (j <= TO) ? 32'd0 : 32'd1);
            if (j == k) begin
                lsu_wb_valid = 1'b1;
                lsu_wb_rdata = w;
            end
            @(posedge clk); #1;
            lsu_wb_valid = 1'b0;
            lsu_wb_rdata = $urandom;
        end
        chk("stall_after", 32'(wb_ifu_stall), 32'd0);
        chk("ready_after", 32'(ex_wb_ready), 32'd1);
    endtask

    task automatic drain();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        rst_n = 1'b0;
        ex_wb_valid = 1'b0; ex_wb_typ = '0; ex_wb_rd_addr = '0;
        ex_wb_alu_data = '0; ex_wb_csr_rdata = '0; ex_wb_funct3 = '0;
        ex_wb_byte_off = '0; lsu_wb_valid = 1'b0; lsu_wb_rdata = '0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ex_wb_ready), 32'd0);
        chk("rst_we", 32'(wb_gpr_write_en), 32'd0);
        chk("rst_addr", 32'(wb_gpr_write_addr), 32'd0);
        chk("rst_data", wb_gpr_wdata, 32'd0);
        chk("rst_stall", 32'(wb_ifu_stall), 32'd0);
        chk("rst_pend", 32'(wb_load_pending_addr), 32'd0);
        chk("rst_err", 32'(wb_load_err), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst", 32'(ex_wb_ready), 32'd1);
        mon_en = 1'b1;

        // Back-to-back ALU ops
        do_alu(0, 1, 32'h11);
        do_alu(0, 2, 32'h22);
        do_alu(0, 3, 32'h33);
        drain();

        // Loads: sign/zero extension and alignment
        do_load(5, 0, 3, 32'h80FF_0000, 4);
        do_load(5, 4, 3, 32'h80FF_0000, 4);
        do_load(6, 1, 2, 32'h8001_1234, 2);
        do_load(6, 5, 2, 32'h8001_1234, 1);
        do_load(6, 2, 2, 32'h8001_1234, 3);
        do_load(0, 0, 0, 32'hFFFF_FFFF, 2);
        do_alu(2, 7, 32'hDEAD_BEEF);
        drain();

        // Timeout (stale response ignored), then response on expiry cycle
        do_load(9, 2, 0, 32'h1234_5678, TO + 3);
        do_load(10, 2, 0, 32'hCAFE_F00D, TO);
        drain();

        // Reset while a load is outstanding, then a late response
        send(1, 12, 32'h0, 32'h0, 2, 0, acc);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        last_addr = '0;
        last_data = '0;
        chk("midrst_ready", 32'(ex_wb_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        lsu_wb_valid = 1'b1;
        lsu_wb_rdata = 32'hAAAA_5555;
        @(posedge clk); #1;
        lsu_wb_valid = 1'b0;
        chk("midrst_stall", 32'(wb_ifu_stall), 32'd0);
        chk("midrst_pend", 32'(wb_load_pending_addr), 32'd0);
        chk("midrst_addr", 32'(wb_gpr_write_addr), 32'd0);
        chk("midrst_data", wb_gpr_wdata, 32'd0);
        drain();

        // Random traffic
        for (int n = 0; n < 80; n++) begin
            int typ, rd;
            typ = $urandom_range(0, 3);
            rd  = $urandom_range(0, 31);
            if (typ == 1)
                do_load(rd, $urandom_range(0, 7), $urandom_range(0, 3), $urandom,
                        $urandom_range(1, TO + 3));
            else
                do_alu(typ, rd, $urandom);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        drain();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global guard against a hung run
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
